// File: rtl/musicbox_pkg.sv
// Shared types and constants for the music box playback path.
// Holds the playback state enum, time constants and an elapsed-seconds helper.
package musicbox_pkg;

  localparam int SEC_PER_MIN   = 60;
  localparam int ELAPSED_W     = 12;
  localparam int MAX_ELAPSED_S = 3599;
  localparam int TIME_W        = 6;

  typedef enum logic [2:0] {
    PAUSE1,
    PLAY1,
    PAUSE2,
    PLAY2,
    STOP
  } pb_state_t;

  // 63:63 is the largest input, which is 3843 and fits in 12 bits.
  function automatic logic [ELAPSED_W-1:0] elapsed_s(
    input logic [TIME_W-1:0] mins,
    input logic [TIME_W-1:0] secs
  );
    logic [ELAPSED_W-1:0] m;
    logic [ELAPSED_W-1:0] s;
    m = ELAPSED_W'(mins);
    s = ELAPSED_W'(secs);
    return m * ELAPSED_W'(SEC_PER_MIN) + s;
  endfunction

endpackage

// File: rtl/playback_ctrl_if.sv
// Bus between button front-end / elapsed counter and the playback controller.
// master: requests and counter time in, status out. slave: the controller.
interface playback_ctrl_if;
  import musicbox_pkg::*;

  logic              pause_req;
  logic              skip_req;
  logic [TIME_W-1:0] mins1;
  logic [TIME_W-1:0] secs1;
  logic [TIME_W-1:0] mins2;
  logic [TIME_W-1:0] secs2;
  logic              song_sel;
  logic              ispaused;
  logic              pause_ack;
  logic              skip_ack;
  logic              song_end;
  logic              stopped;

  modport master (
    output pause_req, skip_req,
    output mins1, secs1, mins2, secs2,
    input  song_sel, ispaused,
    input  pause_ack, skip_ack,
    input  song_end, stopped
  );

  modport slave (
    input  pause_req, skip_req,
    input  mins1, secs1, mins2, secs2,
    output song_sel, ispaused,
    output pause_ack, skip_ack,
    output song_end, stopped
  );

endinterface

// File: rtl/playback_ctrl_handshake_rx.sv
// Four-phase req/ack acceptor. Ports: clk, RESET (async, active-high), req in;
// ack (registered) and accept (one-cycle pulse on the accepting edge) out.
module handshake_rx (
  input  logic clk,
  input  logic RESET,
  input  logic req,
  output logic ack,
  output logic accept
);

  logic ack_q;
  logic ack_d;
  logic armed_q;
  logic armed_d;

  // Armed only re-sets once ack has dropped, so a held req acts once.
  always_comb begin
    accept  = req & ~ack_q & armed_q;
    ack_d   = ack_q;
    armed_d = armed_q;
    if (accept) begin
      ack_d   = 1'b1;
      armed_d = 1'b0;
    end else if (ack_q && !req) begin
      ack_d   = 1'b0;
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      ack_q   <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      ack_q   <= ack_d;
      armed_q <= armed_d;
    end
  end

  assign ack = ack_q;

endmodule

// File: rtl/playback_ctrl.sv
// Playback FSM: pause/skip over four-phase handshakes, auto-advance at song end.
// Ports: clk_1hz, RESET (async, active-high), bus (playback_ctrl_if.slave).
// Macro PLAYBACK_LOOP_EN: song 2 end loops to song 1 instead of stopping.
module playback_ctrl
  import musicbox_pkg::*;
#(
  parameter int SONG1_LEN_S = 95,
  parameter int SONG2_LEN_S = 130
) (
  input logic             clk_1hz,
  input logic             RESET,
  playback_ctrl_if.slave  bus
);

  localparam int L1 =
    (SONG1_LEN_S > MAX_ELAPSED_S) ? MAX_ELAPSED_S : SONG1_LEN_S;
  localparam int L2 =
    (SONG2_LEN_S > MAX_ELAPSED_S) ? MAX_ELAPSED_S : SONG2_LEN_S;
  localparam logic [ELAPSED_W-1:0] LEN1 = ELAPSED_W'(L1);
  localparam logic [ELAPSED_W-1:0] LEN2 = ELAPSED_W'(L2);

  pb_state_t state_q;
  pb_state_t state_d;
  logic      end_q;
  logic      end_d;

  logic pause_acc;
  logic skip_acc;
  logic pause_ack;
  logic skip_ack;

  logic [ELAPSED_W-1:0] el1;
  logic [ELAPSED_W-1:0] el2;
  logic                 end_hit;
  pb_state_t            end_nxt;

  handshake_rx u_pause (
    .clk    (clk_1hz),
    .RESET  (RESET),
    .req    (bus.pause_req),
    .ack    (pause_ack),
    .accept (pause_acc)
  );

  handshake_rx u_skip (
    .clk    (clk_1hz),
    .RESET  (RESET),
    .req    (bus.skip_req),
    .ack    (skip_ack),
    .accept (skip_acc)
  );

  assign el1 = elapsed_s(bus.mins1, bus.secs1);
  assign el2 = elapsed_s(bus.mins2, bus.secs2);

  always_comb begin
    end_hit = 1'b0;
    end_nxt = state_q;
    unique case (state_q)
      PLAY1: begin
        end_hit = (el1 >= LEN1);
        end_nxt = PLAY2;
      end
      PLAY2: begin
        end_hit = (el2 >= LEN2);
`ifdef PLAYBACK_LOOP_EN
        end_nxt = PLAY1;
`else
        end_nxt = STOP;
`endif
      end
      default: ;
    endcase
  end

  // Skip beats end-of-song beats pause; a losing pause is dropped.
  always_comb begin
    state_d = state_q;
    end_d   = 1'b0;
    unique case (1'b1)
      skip_acc: begin
        unique case (state_q)
          PAUSE1, PLAY1: state_d = PLAY2;
          default:       state_d = PLAY1;
        endcase
      end
      !skip_acc && end_hit: begin
        state_d = end_nxt;
        end_d   = 1'b1;
      end
      !skip_acc && !end_hit && pause_acc: begin
        unique case (state_q)
          PAUSE1:  state_d = PLAY1;
          PLAY1:   state_d = PAUSE1;
          PAUSE2:  state_d = PLAY2;
          PLAY2:   state_d = PAUSE2;
          default: state_d = PLAY1;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_1hz or posedge RESET) begin
    if (RESET) begin
      state_q <= PAUSE1;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      end_q   <= end_d;
    end
  end

  always_comb begin
    bus.song_sel  = (state_q == PAUSE2) || (state_q == PLAY2) ||
                    (state_q == STOP);
    bus.ispaused  = (state_q == PAUSE1) || (state_q == PAUSE2) ||
                    (state_q == STOP);
    bus.stopped   = (state_q == STOP);
    bus.song_end  = end_q;
    bus.pause_ack = pause_ack;
    bus.skip_ack  = skip_ack;
  end

endmodule

// File: tb/tb_playback_ctrl.sv
// Self-checking bench for playback_ctrl: vector table plus expected-value queue.
// Output word order: {song_sel, ispaused, pause_ack, skip_ack, song_end, stopped}.
module tb_playback_ctrl;

`ifdef PLAYBACK_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk_1hz = 1'b0;
  logic RESET   = 1'b1;

  playback_ctrl_if bus ();

  playback_ctrl #(
    .SONG1_LEN_S (95),
    .SONG2_LEN_S (130)
  ) dut (
    .clk_1hz (clk_1hz),
    .RESET   (RESET),
    .bus     (bus.slave)
  );

  always #5 clk_1hz = ~clk_1hz;

  typedef struct {
    logic       p;
    logic       s;
    logic [5:0] m1;
    logic [5:0] s1;
    logic [5:0] m2;
    logic [5:0] s2;
    logic [5:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] sb[$];
  int         errors = 0;
  int         checks = 0;

  function automatic vec_t mk(
    input logic p, input logic s,
    input logic [5:0] m1, input logic [5:0] s1,
    input logic [5:0] m2, input logic [5:0] s2,
    input logic [5:0] exp
  );
    vec_t v;
    v.p = p; v.s = s;
    v.m1 = m1; v.s1 = s1; v.m2 = m2; v.s2 = s2;
    v.exp = exp;
    return v;
  endfunction

  function automatic logic [5:0] outs();
    return {bus.song_sel, bus.ispaused, bus.pause_ack,
            bus.skip_ack, bus.song_end, bus.stopped};
  endfunction

  task automatic check(input string name, input logic [5:0] want);
    logic [5:0] got;
    got = outs();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  // Drive at negedge, queue the expectation, compare after the edge.
  task automatic step(input string name, input vec_t v);
    @(negedge clk_1hz);
    bus.pause_req = v.p;
    bus.skip_req  = v.s;
    bus.mins1 = v.m1; bus.secs1 = v.s1;
    bus.mins2 = v.m2; bus.secs2 = v.s2;
    sb.push_back(v.exp);
    @(posedge clk_1hz);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", name);
    end else begin
      check(name, sb.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] e15;
    logic [5:0] e16;
    logic [5:0] e17;
    logic [5:0] e18;
    bus.pause_req = 1'b0;
    bus.skip_req  = 1'b0;
    bus.mins1 = '0; bus.secs1 = '0;
    bus.mins2 = '0; bus.secs2 = '0;

    e15 = LOOP ? 6'b000010 : 6'b110011;
    e16 = LOOP ? 6'b000000 : 6'b110001;
    e17 = LOOP ? 6'b011000 : 6'b001000;
    e18 = LOOP ? 6'b010000 : 6'b000000;

    vecs.push_back(mk(1, 0, 0, 0,  0, 0,  6'b001000));
    vecs.push_back(mk(1, 0, 0, 0,  0, 0,  6'b001000));
    vecs.push_back(mk(1, 0, 0, 0,  0, 0,  6'b001000));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,  6'b000000));
    vecs.push_back(mk(0, 0, 1, 34, 0, 0,  6'b000000));
    vecs.push_back(mk(0, 0, 1, 35, 0, 0,  6'b100010));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,  6'b100000));
    vecs.push_back(mk(1, 0, 0, 0,  0, 0,  6'b111000));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,  6'b110000));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0,  6'b000100));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,  6'b000000));
    vecs.push_back(mk(1, 1, 0, 0,  0, 0,  6'b101100));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,  6'b100000));
    vecs.push_back(mk(0, 0, 0, 0,  2, 9,  6'b100000));
    vecs.push_back(mk(0, 0, 0, 0,  2, 10, e15));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,  e16));
    vecs.push_back(mk(1, 0, 0, 0,  0, 0,  e17));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0,  e18));

    #2;
    check("reset_state", 6'b010000);
    @(negedge clk_1hz);
    RESET = 1'b0;

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Skip held across reset: ack drops at once, req re-accepted after.
    step("skip_go", mk(0, 1, 0, 0, 0, 0, 6'b100100));
    step("skip_held", mk(0, 1, 0, 0, 0, 0, 6'b100100));
    @(negedge clk_1hz);
    RESET = 1'b1;
    #1;
    check("reset_mid_hs", 6'b010000);
    #2;
    RESET = 1'b0;
    step("skip_after_rst", mk(0, 1, 0, 0, 0, 0, 6'b100100));
    step("skip_release", mk(0, 0, 0, 0, 0, 0, 6'b100000));

    // Pause during end-of-song edge: end wins, pause toggle dropped.
    step("to_play1", mk(0, 1, 0, 0, 0, 0, 6'b000100));
    step("skip_low", mk(0, 0, 0, 0, 0, 0, 6'b000000));
    step("end_vs_pause", mk(1, 0, 1, 35, 0, 0, 6'b101010));
    step("pause_low", mk(0, 0, 0, 0, 0, 0, 6'b100000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
